// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing a one-cycle-latency instruction memory between N_MASTERS ibus ports.
// Optional out-of-range fetch trapping is built in when IMEM_ARB_BOUNDS_EN is defined.
module imem_fetch_arbiter #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [N_MASTERS-1:0]     i_ibus_cyc,
  input  logic [32*N_MASTERS-1:0]  i_ibus_adr,
  output logic [31:0]              o_ibus_rdt,
  output logic [N_MASTERS-1:0]     o_ibus_ack,
  output logic [31:0]              o_mem_addr,
  input  logic [31:0]              i_mem_data,
  output logic                     o_busy
`ifdef IMEM_ARB_BOUNDS_EN
  ,
  output logic                     o_bounds_err
`endif
);

  localparam int unsigned PW  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ACK
  } state_e;

  state_e               state_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        grant_q;
  logic [N_MASTERS-1:0] mask_q;

  logic [N_MASTERS-1:0] req;
  logic                 win_valid;
  logic [PW-1:0]        win_idx;
  logic [PW-1:0]        cand;
  logic [31:0]          win_adr;
  logic [31:0]          win_word;
  logic                 unused_adr_lsbs;

  // First requester at or after the pointer, wrapping; the just-acked core is masked.
  always_comb begin
    req       = i_ibus_cyc & ~mask_q;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      cand = PW'((32'(ptr_q) + i) % N_MASTERS);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_adr         = i_ibus_adr[{win_idx, 5'b00000} +: 32];
  assign win_word        = {2'b00, win_adr[31:2]};
  assign unused_adr_lsbs = ^win_adr[1:0];

`ifdef IMEM_ARB_BOUNDS_EN
  logic oob_q;
  logic bounds_err_q;
  logic win_oob;

  assign win_oob      = (win_word >= DEPTH);
  assign o_bounds_err = bounds_err_q;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      mask_q       <= '0;
      o_mem_addr   <= '0;
      o_ibus_rdt   <= '0;
      o_ibus_ack   <= '0;
      o_busy       <= 1'b0;
`ifdef IMEM_ARB_BOUNDS_EN
      oob_q        <= 1'b0;
      bounds_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          mask_q <= '0;
          if (win_valid) begin
            grant_q <= win_idx;
            ptr_q   <= (win_idx == PW'(N_MASTERS - 1)) ? '0 : win_idx + 1'b1;
`ifdef IMEM_ARB_BOUNDS_EN
            o_mem_addr <= win_oob ? '0 : win_word;
            oob_q      <= win_oob;
`else
            o_mem_addr <= win_word;
`endif
            o_busy  <= 1'b1;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          state_q <= S_DATA;
        end
        S_DATA: begin
`ifdef IMEM_ARB_BOUNDS_EN
          o_ibus_rdt   <= oob_q ? NOP : i_mem_data;
          bounds_err_q <= oob_q;
`else
          o_ibus_rdt <= i_mem_data;
`endif
          // An aborted fetch still completes the read but earns no ack and no mask.
          if (i_ibus_cyc[grant_q]) begin
            o_ibus_ack[grant_q] <= 1'b1;
            mask_q <= {{(N_MASTERS-1){1'b0}}, 1'b1} << grant_q;
          end
          state_q <= S_ACK;
        end
        S_ACK: begin
          o_ibus_ack <= '0;
`ifdef IMEM_ARB_BOUNDS_EN
          bounds_err_q <= 1'b0;
`endif
          o_busy  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Randomized self-checking bench for imem_fetch_arbiter against a transaction-level schedule model.
module tb_imem_fetch_arbiter;

  localparam int NM      = 4;
  localparam int DEPTH_P = 256;

  logic                i_clk = 1'b0;
  logic                i_reset;
  logic [NM-1:0]       cyc;
  logic [32*NM-1:0]    adr;
  logic [31:0]         o_ibus_rdt;
  logic [NM-1:0]       o_ibus_ack;
  logic [31:0]         o_mem_addr;
  logic [31:0]         mem_q;
  logic                o_busy;
`ifdef IMEM_ARB_BOUNDS_EN
  logic                o_bounds_err;
`endif

  imem_fetch_arbiter #(.N_MASTERS(NM), .DEPTH(DEPTH_P)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_ibus_cyc  (cyc),
    .i_ibus_adr  (adr),
    .o_ibus_rdt  (o_ibus_rdt),
    .o_ibus_ack  (o_ibus_ack),
    .o_mem_addr  (o_mem_addr),
    .i_mem_data  (mem_q),
    .o_busy      (o_busy)
`ifdef IMEM_ARB_BOUNDS_EN
    ,
    .o_bounds_err(o_bounds_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'd2) return 32'h0031_8333;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Registered-read instruction memory.
  always @(posedge i_clk) mem_q <= memfn(o_mem_addr);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Transaction-level model: a grant at cycle t occupies cycles t+1..t+3,
  // ack decided by cyc at t+2, next grant possible at t+4.
  int          cyc_n;
  int          m_ptr, m_t0, m_g, m_free, m_mask_core, m_mask_cycle;
  bit          m_act, m_ackp, m_oob;
  logic [31:0] m_word;
  logic [31:0] e_addr, e_rdt;
  logic [NM-1:0] e_ack;
  logic        e_busy, e_berr;

  task automatic model_reset();
    m_ptr = 0; m_act = 0; m_ackp = 0; m_oob = 0; m_t0 = 0; m_g = 0; m_word = '0;
    m_free = cyc_n; m_mask_core = -1; m_mask_cycle = -100;
    e_addr = '0; e_rdt = '0; e_ack = '0; e_busy = 0; e_berr = 0;
  endtask

  task automatic model_step();
    int n, w, c, k;
    n = cyc_n;
    w = -1;
    if (m_act && n == m_t0 + 2) m_ackp = cyc[m_g];
    if (n >= m_free) begin
      for (int i = 0; i < NM; i++) begin
        c = (m_ptr + i) % NM;
        if (w < 0 && cyc[c] && !(n == m_mask_cycle && c == m_mask_core)) w = c;
      end
      if (w >= 0) begin
        m_act  = 1; m_t0 = n; m_g = w; m_ackp = 0;
        m_word = adr[32*w +: 32] >> 2;
`ifdef IMEM_ARB_BOUNDS_EN
        m_oob  = (m_word >= DEPTH_P);
`else
        m_oob  = 0;
`endif
        m_free = n + 4;
        m_ptr  = (w + 1) % NM;
      end
    end
    e_ack = '0; e_berr = 0; e_busy = 0;
    if (m_act) begin
      k = n + 1 - m_t0;
      e_busy = (k >= 1 && k <= 3);
      if (k == 1) e_addr = m_oob ? 32'd0 : m_word;
      if (k == 3) begin
        e_rdt  = m_oob ? 32'h0000_0013 : memfn(m_word);
        e_berr = m_oob;
        if (m_ackp) begin
          e_ack        = NM'(1) << m_g;
          m_mask_core  = m_g;
          m_mask_cycle = n + 2;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    #1;
    check("busy", 32'(o_busy), 32'(e_busy));
    check("ack", 32'(o_ibus_ack), 32'(e_ack));
    check("mem_addr", o_mem_addr, e_addr);
    check("rdt", o_ibus_rdt, e_rdt);
`ifdef IMEM_ARB_BOUNDS_EN
    check("bounds_err", 32'(o_bounds_err), 32'(e_berr));
`endif
    cyc_n++;
    @(negedge i_clk);
  endtask

  // Called at a negedge; reset acts immediately and releases at the next negedge.
  task automatic do_reset();
    i_reset = 1'b1;
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ack", 32'(o_ibus_ack), 32'd0);
    check("rst_mem_addr", o_mem_addr, 32'd0);
    check("rst_rdt", o_ibus_rdt, 32'd0);
`ifdef IMEM_ARB_BOUNDS_EN
    check("rst_bounds_err", 32'(o_bounds_err), 32'd0);
`endif
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] rand_adr();
    if ($urandom_range(0, 7) == 0) return $urandom();
    return (32'($urandom_range(0, 299)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  int exp_core[5] = '{0, 1, 2, 3, 0};
  logic [NM-1:0] ack_prev;

  initial begin
    i_reset = 1'b0;
    cyc     = '0;
    adr     = '0;
    cyc_n   = 0;
    model_reset();
    @(negedge i_clk);
    do_reset();

    // Single fetch from core 0 at byte address 8.
    cyc = 4'b0001; adr[31:0] = 32'h0000_0008;
    tick();
    check("t1_mem_addr", o_mem_addr, 32'd2);
    tick(); tick();
    check("t1_ack", 32'(o_ibus_ack), 32'h1);
    check("t1_rdt", o_ibus_rdt, 32'h0031_8333);
    tick();
    cyc = '0;
    repeat (3) tick();

    // All cores requesting continuously from reset.
    do_reset();
    cyc = 4'b1111;
    for (int k = 0; k < NM; k++) adr[32*k +: 32] = 32'(32'h40 * k + 4);
    for (int c = 0; c < 20; c++) begin
      tick();
      if ((c + 1) % 4 == 3) check("rr_ack", 32'(o_ibus_ack), 32'(4'b0001 << exp_core[(c + 1) / 4]));
    end
    cyc = '0;
    repeat (4) tick();

    // Core 2 aborts in ADDR while core 3 starts requesting.
    do_reset();
    cyc = 4'b0100; adr[95:64] = 32'h40; adr[127:96] = 32'h80;
    tick();
    cyc = 4'b1000;
    tick(); tick();
    check("abort_noack", 32'(o_ibus_ack), 32'd0);
    tick();
    check("abort_idle", 32'(o_busy), 32'd0);
    tick();
    check("abort_next_addr", o_mem_addr, 32'h20);
    tick(); tick();
    check("abort_next_ack", 32'(o_ibus_ack), 32'h8);
    cyc = '0;
    repeat (2) tick();

    // Reset during DATA drops the fetch.
    do_reset();
    cyc = 4'b0001; adr[31:0] = 32'h10;
    tick(); tick();
    cyc = '0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rst_noack", 32'(o_ibus_ack), 32'd0);
    end
    cyc = 4'b1110; adr[63:32] = 32'h24;
    tick(); tick(); tick();
    check("rst_next_ack", 32'(o_ibus_ack), 32'h2);
    cyc = '0;
    repeat (4) tick();

    // Core 0 holds cyc past its ack while core 1 requests.
    do_reset();
    cyc = 4'b0001; adr[31:0] = 32'h0C;
    repeat (4) tick();
    cyc = 4'b0011; adr[63:32] = 32'h44;
    tick();
    check("mask_grant_addr", o_mem_addr, 32'h11);
    cyc = 4'b0010;
    tick(); tick();
    check("mask_grant_ack", 32'(o_ibus_ack), 32'h2);
    cyc = '0;
    repeat (2) tick();

    // Lone core held past its ack is skipped for exactly one IDLE cycle.
    do_reset();
    cyc = 4'b0001; adr[31:0] = 32'h0C;
    repeat (5) tick();
    check("mask_idle", 32'(o_busy), 32'd0);
    tick();
    check("mask_regrant", 32'(o_busy), 32'd1);
    cyc = '0;
    repeat (4) tick();

`ifdef IMEM_ARB_BOUNDS_EN
    do_reset();
    cyc = 4'b0010; adr[63:32] = 32'h400;
    tick();
    check("oob_mem_addr", o_mem_addr, 32'd0);
    tick(); tick();
    check("oob_rdt", o_ibus_rdt, 32'h0000_0013);
    check("oob_ack", 32'(o_ibus_ack), 32'h2);
    check("oob_err", 32'(o_bounds_err), 32'd1);
    cyc = '0;
    repeat (2) tick();
`endif

    // Randomized traffic.
    ack_prev = '0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) == 0) begin
        cyc = '0;
        ack_prev = '0;
        do_reset();
      end
      for (int k = 0; k < NM; k++) begin
        int r;
        r = $urandom_range(0, 15);
        if (cyc[k]) begin
          if ((ack_prev[k] && r < 10) || r == 0) cyc[k] = 1'b0;
          else if (r == 1) adr[32*k +: 32] = rand_adr();
        end else if (r < 5) begin
          cyc[k] = 1'b1;
          adr[32*k +: 32] = rand_adr();
        end
      end
      ack_prev = o_ibus_ack;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
